// File: rtl/seq_det_rr_sched.sv
// Shared "101" sequence detector time-multiplexed across NCH serial channels.
// A round-robin arbiter picks one requesting channel per cycle; each channel keeps its own context and match counter.
module seq_det_rr_sched #(
  parameter  int NCH = 4,
  parameter  int CW  = 8,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    x,
  input  logic              clr,
  output logic [NCH-1:0]    gnt,
  output logic              det_valid,
  output logic [IW-1:0]     det_ch,
  output logic [NCH*CW-1:0] cnt_flat
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;

  logic [1:0]    ctx_q [NCH];
  logic [1:0]    ctx_d [NCH];
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  logic [IW-1:0] rr_q, rr_d;
  logic          det_valid_q, det_valid_d;
  logic [IW-1:0] det_ch_q, det_ch_d;

  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;
  logic          match;

  // Search starts one past the last granted channel; idle channels cost no cycles.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst && en) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = IW'((int'(rr_q) + k) % NCH);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ctx_d       = ctx_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    det_valid_d = 1'b0;
    det_ch_d    = det_ch_q;
    match       = 1'b0;

    if (gnt_any) begin
      rr_d = gnt_idx;
      case (ctx_q[gnt_idx])
        S0:      ctx_d[gnt_idx] = x[gnt_idx] ? S1 : S0;
        S1:      ctx_d[gnt_idx] = x[gnt_idx] ? S1 : S2;
        S2: begin
          ctx_d[gnt_idx] = x[gnt_idx] ? S1 : S0;
          match          = x[gnt_idx];
        end
        default: ctx_d[gnt_idx] = S0;
      endcase
    end

    if (match) begin
      det_valid_d = 1'b1;
      det_ch_d    = gnt_idx;
      if (cnt_q[gnt_idx] != '1) cnt_d[gnt_idx] = cnt_q[gnt_idx] + CW'(1);
    end

    // Clear wins over a same-cycle match: the granted bit is dropped, but the pointer still advances.
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_d[i] = S0;
        cnt_d[i] = '0;
      end
      det_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the per-channel context/counter arrays are reset element by element; they are flops, not RAM.
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
        cnt_q[i] <= '0;
      end
      rr_q        <= IW'(NCH - 1);
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= ctx_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      rr_q        <= rr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_flat
    assign cnt_flat[g*CW +: CW] = cnt_q[g];
  end

endmodule

// File: doc/seq_det_rr_sched.md
SEQ_DET_RR_SCHED -- requirements
Module: seq_det_rr_sched

Interface
REQ-001 Parameter NCH, default 4, number of serial input channels sharing one 101 detector core.
REQ-002 Parameter CW, default 8, width of each per-channel match counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  scheduler enable; 0 = no grants issued, all state held.
REQ-006 req  input  NCH  per-channel request; bit i high = channel i presents a bit on x[i].
REQ-007 x  input  NCH  per-channel serial data bit, valid while req[i] high.
REQ-008 clr  input  1  synchronous clear of all counters and detector contexts.
REQ-009 gnt  output  NCH  one-hot (or zero) grant, combinational from req, en and rr pointer.
REQ-010 det_valid  output  1  registered pulse: a 101 match completed on the previous grant.
REQ-011 det_ch  output  log2(NCH)  registered channel index of the match; valid only with det_valid.
REQ-012 cnt_flat  output  NCH*CW  registered match counters, channel i at bits [i*CW +: CW].

Function
REQ-013 The block SHALL keep a 2-bit detector context per channel: S0 idle, S1 seen "1", S2 seen "10".
REQ-014 Context transitions SHALL be: S0: x=1->S1, x=0->S0; S1: x=1->S1, x=0->S2; S2: x=1->S1 with match, x=0->S0 (Mealy, overlapping).
REQ-015 When en=1 and req!=0, gnt SHALL select exactly one requesting channel, searching round-robin starting at the channel after the last granted one.
REQ-016 When en=0 or req=0, gnt SHALL be all zeros and the rr pointer, contexts and counters SHALL hold.
REQ-017 A bit is consumed at the rising edge where gnt[i]=1; only the granted channel's context SHALL update that cycle; ungranted channels hold.
REQ-018 The rr pointer SHALL update to the granted index on every consumed bit.
REQ-019 A match SHALL set det_valid=1 and det_ch=i for exactly one cycle following the consuming edge (latency 1); otherwise det_valid=0.
REQ-020 A match SHALL increment counter i by 1, saturating at 2^CW-1 (no wrap).
REQ-021 clr=1 SHALL reset all contexts to S0, all counters to 0 and suppress det_valid at that edge; clr SHALL take priority over a simultaneous grant/match (the bit is discarded, gnt still driven).
REQ-022 A requester is responsible for holding req[i] and x[i] until it sees gnt[i]; the block SHALL NOT buffer unconsumed bits.
REQ-023 Channels whose req is low SHALL be skipped by the round-robin search with no cycle penalty.

Reset
REQ-024 While rst=0: all contexts S0, all counters 0, det_valid=0, det_ch=0, rr pointer = NCH-1 (so channel 0 has first priority); gnt SHALL be 0.
REQ-025 Reset assertion mid-stream SHALL discard any partial sequence; first bits after release start from S0.

Verification
REQ-026 Ch0 only, en=1, bits 0,1,1,1,0,1,0,0,1,0,1,0,1 -> det_valid with det_ch=0 three times (after 6th, 11th, 13th bits); cnt ch0=3, others 0.
REQ-027 req=4'b1111 held, en=1 -> gnt sequence 0001,0010,0100,1000,0001 from first cycle after reset release.
REQ-028 Ch0 and ch1 both requesting, each streaming 1,0,1 interleaved by grants -> each context independent; two matches, det_ch=0 then det_ch=1; cnt0=1, cnt1=1.
REQ-029 Ch2 driven to S2 (bits 1,0), then rst pulsed low, then ch2 bit 1 -> no match; cnt2=0.
REQ-030 Ch3 fed 260 consecutive "101" overlapping matches (1,0,1,0,1,...) -> cnt3=255 and holds; clr=1 on a match edge -> cnt3=0, det_valid=0 next cycle.
REQ-031 en=0 with req=4'b1111 for 5 cycles -> gnt=0, counters/contexts unchanged; en=1 resumes from pointer position held before.
